// File: rtl/frag_buffer_write_arbiter_pkg.sv
// Shared types and constants for the fragmentation-buffer write arbiter:
// FSM state encoding, requester indices and default buffer geometry.
package frag_buffer_write_arbiter_pkg;

  localparam int DEF_BUFFER_WIDTH = 128;
  localparam int DEF_BUFFER_DEPTH = 8;

  localparam logic REQ_AXI = 1'b0;
  localparam logic REQ_RX  = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    XFER       = 2'd2
  } arb_state_t;

endpackage

// File: rtl/frag_rr_arbiter_2.sv
// Two-way round-robin selector; the pointer moves to the requester that was
// not served whenever i_update strobes.
module frag_rr_arbiter_2
  import frag_buffer_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served,
  output logic       o_winner
);

  logic r_ptr;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_ptr <= REQ_AXI;
    end else if (i_update) begin
      r_ptr <= ~i_served;
    end
  end

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    o_winner = r_ptr;
    if (i_req == 2'b01) begin
      o_winner = REQ_AXI;
    end else if (i_req == 2'b10) begin
      o_winner = REQ_RX;
    end
  end

endmodule

// File: rtl/frag_buffer_write_arbiter.sv
// Arbitrates the AXI TX and RX completion paths onto the fragmentation-buffer
// write port, one whole TLP at a time. FRAG_ARB_STRICT_PRIO_EN: requester 0 always wins.
module frag_buffer_write_arbiter
  import frag_buffer_write_arbiter_pkg::*;
#(
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [1:0]                req,
  input  logic [2*BUFFER_DEPTH-1:0] req_len,
  input  logic [1:0]                beat_valid,
  input  logic [2*BUFFER_WIDTH-1:0] beat_data,
  input  logic [2*BUFFER_DEPTH-1:0] beat_nloc,
  output logic [1:0]                grant,
  output logic [1:0]                beat_ready,
  output logic                      len_err,
  output logic                      wr_en,
  output logic [BUFFER_WIDTH-1:0]   data_in,
  output logic [BUFFER_DEPTH-1:0]   no_loc_wr,
  input  logic [BUFFER_DEPTH-1:0]   empty_loc,
  output logic [1:0]                dbg_state
);

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic                    r_winner;
  logic [BUFFER_DEPTH-1:0] r_remaining;
  logic                    w_sel;
  logic [BUFFER_DEPTH-1:0] w_sel_len;
  logic [BUFFER_DEPTH-1:0] w_nloc;
  logic [BUFFER_DEPTH-1:0] w_loc;
  logic [BUFFER_WIDTH-1:0] w_data;
  logic                    w_fire;
  logic                    w_over;
  logic                    w_done;

`ifdef FRAG_ARB_STRICT_PRIO_EN
  assign w_sel = req[REQ_AXI] ? REQ_AXI : REQ_RX;
`else
  frag_rr_arbiter_2 u_rr (
    .clk      (clk),
    .arst     (arst),
    .i_req    (req),
    .i_update (w_done),
    .i_served (r_winner),
    .o_winner (w_sel)
  );
`endif

  assign w_sel_len = w_sel    ? req_len[2*BUFFER_DEPTH-1:BUFFER_DEPTH]   : req_len[BUFFER_DEPTH-1:0];
  assign w_nloc    = r_winner ? beat_nloc[2*BUFFER_DEPTH-1:BUFFER_DEPTH] : beat_nloc[BUFFER_DEPTH-1:0];
  assign w_data    = r_winner ? beat_data[2*BUFFER_WIDTH-1:BUFFER_WIDTH] : beat_data[BUFFER_WIDTH-1:0];

  // A zero-length TLP still gets its grant cycle but can never write.
  assign w_fire = (r_state == XFER) && beat_valid[r_winner] && (r_remaining != '0);
  assign w_over = w_nloc > r_remaining;
  assign w_loc  = w_over ? r_remaining : w_nloc;
  assign w_done = (r_state == XFER) &&
                  ((r_remaining == '0) || (w_fire && (w_nloc >= r_remaining)));

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake: a beat moves when beat_valid and beat_ready are both high in
  // the same cycle; beat_ready mirrors grant and only the winner ever sees it.
  always_comb begin
    w_next_state = r_state;
    grant        = 2'b00;
    case (r_state)
      IDLE: begin
        if (|req) w_next_state = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (empty_loc >= r_remaining) w_next_state = XFER;
      end
      XFER: begin
        grant = (r_winner == REQ_RX) ? 2'b10 : 2'b01;
        if (w_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    beat_ready = grant;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_winner    <= REQ_AXI;
      r_remaining <= '0;
      wr_en       <= 1'b0;
      len_err     <= 1'b0;
      data_in     <= '0;
      no_loc_wr   <= '0;
    end else begin
      wr_en   <= w_fire;
      len_err <= w_fire && w_over;
      if ((r_state == IDLE) && (|req)) begin
        r_winner    <= w_sel;
        r_remaining <= w_sel_len;
      end
      if (w_fire) begin
        data_in     <= w_data;
        no_loc_wr   <= w_loc;
        r_remaining <= r_remaining - w_loc;
      end
    end
  end

endmodule
